// File: rtl/arm_control_unit.sv
// Single-cycle ARM control unit: main/ALU decode, NZCV flag register and condition gating.
// Define CONTROL_UNIT_CMP_EN to decode DP cmd 1010 as CMP (SUB, no register write).
module arm_control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Rd,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Cond,
   input  logic       N,
   input  logic       Z,
   input  logic       C,
   input  logic       V,
   output logic       PCSrc,
   output logic       MemtoReg,
   output logic       MemWrite,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [1:0] RegSrc
);

   logic       reg_w;
   logic       mem_w;
   logic       branch;
   logic       alu_op;
   logic       no_write;
   logic [1:0] flag_w;
   logic [3:0] flags;
   logic       cond_ex;
   logic       pcs;
   logic       flag_n, flag_z, flag_c, flag_v;
   logic       unused_imm;

   assign unused_imm = Funct[5];
   assign {flag_n, flag_z, flag_c, flag_v} = flags;

   always_comb begin
      reg_w    = 1'b0;
      mem_w    = 1'b0;
      branch   = 1'b0;
      alu_op   = 1'b0;
      MemtoReg = 1'b0;
      ImmSrc   = 2'b00;
      RegSrc   = 2'b00;
      case (Op)
         2'b00: begin
            reg_w  = 1'b1;
            alu_op = 1'b1;
         end
         2'b01: begin
            ImmSrc = 2'b01;
            if (Funct[0]) begin
               MemtoReg = 1'b1;
               reg_w    = 1'b1;
            end else begin
               RegSrc = 2'b10;
               mem_w  = 1'b1;
            end
         end
         2'b10: begin
            RegSrc = 2'b01;
            ImmSrc = 2'b10;
            branch = 1'b1;
         end
         default: ;
      endcase
   end

   // C/V are only meaningful for the arithmetic ops (ADD/SUB), hence the ALUControl[1] mask.
   always_comb begin
      ALUControl = 2'b00;
      no_write   = 1'b0;
      flag_w     = 2'b00;
      if (alu_op) begin
         case (Funct[4:1])
            4'b0100: ALUControl = 2'b00;
            4'b0010: ALUControl = 2'b01;
            4'b0000: ALUControl = 2'b10;
            4'b1100: ALUControl = 2'b11;
`ifdef CONTROL_UNIT_CMP_EN
            4'b1010: begin
               ALUControl = 2'b01;
               no_write   = 1'b1;
            end
`endif
            default: ALUControl = 2'b00;
         endcase
         flag_w = {Funct[0], Funct[0] & ~ALUControl[1]};
      end
   end

   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   assign pcs      = branch | (reg_w & (Rd == 4'hF));
   assign PCSrc    = pcs & cond_ex;
   assign RegWrite = reg_w & ~no_write & cond_ex;
   assign MemWrite = mem_w & cond_ex;

   // Stored flags feed the next instruction's condition; there is no same-cycle bypass.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags <= 4'b0000;
      end else begin
         if (flag_w[1] & cond_ex) flags[3:2] <= {N, Z};
         if (flag_w[0] & cond_ex) flags[1:0] <= {C, V};
      end
   end

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed self-checking bench for arm_control_unit; flags are observed through condition gating.
module tb_arm_control_unit;

   logic       clk;
   logic       reset;
   logic [3:0] Rd;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Cond;
   logic       N, Z, C, V;
   logic       PCSrc, MemtoReg, MemWrite, RegWrite;
   logic [1:0] ALUControl, ImmSrc, RegSrc;

   int checks = 0;
   int errors = 0;

   arm_control_unit dut (
      .clk(clk), .reset(reset), .Rd(Rd), .Op(Op), .Funct(Funct), .Cond(Cond),
      .N(N), .Z(Z), .C(C), .V(V),
      .PCSrc(PCSrc), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .RegSrc(RegSrc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge, so each vector sees exactly one rising edge before the next.
   task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                                input logic [3:0] cond, input logic [3:0] nzcv);
      @(negedge clk);
      Op = op; Funct = funct; Rd = rd; Cond = cond;
      {N, Z, C, V} = nzcv;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      Op = 2'b00; Funct = 6'b001000; Rd = 4'd0; Cond = 4'b1110; {N, Z, C, V} = 4'b0000;
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0000, 4'b0100);
      checkOutput("rst_eq_regwrite", RegWrite, 0);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0001, 4'b0100);
      checkOutput("rst_ne_regwrite", RegWrite, 1);
      reset = 1'b0;

      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b1110, 4'b0000);
      checkOutput("add_aluctl", ALUControl, 2'b00);
      checkOutput("add_regwrite", RegWrite, 1);
      checkOutput("add_pcsrc", PCSrc, 0);
      checkOutput("add_memwrite", MemWrite, 0);

      applyStimulus(2'b01, 6'b000001, 4'd2, 4'b1110, 4'b0000);
      checkOutput("ldr_memtoreg", MemtoReg, 1);
      checkOutput("ldr_regwrite", RegWrite, 1);
      checkOutput("ldr_memwrite", MemWrite, 0);
      checkOutput("ldr_immsrc", ImmSrc, 2'b01);
      checkOutput("ldr_regsrc", RegSrc, 2'b00);

      applyStimulus(2'b01, 6'b000000, 4'd2, 4'b1110, 4'b0000);
      checkOutput("str_memwrite", MemWrite, 1);
      checkOutput("str_regwrite", RegWrite, 0);
      checkOutput("str_regsrc", RegSrc, 2'b10);
      checkOutput("str_memtoreg", MemtoReg, 0);

      applyStimulus(2'b10, 6'b000000, 4'd0, 4'b1110, 4'b0000);
      checkOutput("b_pcsrc", PCSrc, 1);
      checkOutput("b_immsrc", ImmSrc, 2'b10);
      checkOutput("b_regsrc", RegSrc, 2'b01);
      checkOutput("b_regwrite", RegWrite, 0);

      // Input Z must not influence the condition, and S=0 must not write flags.
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0000, 4'b0100);
      checkOutput("eq_input_ignored", RegWrite, 0);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0000, 4'b0100);
      checkOutput("eq_no_s_write", RegWrite, 0);

      // SUB S=1 under EQ with stored Z=0: condition fails, so flags stay clear.
      applyStimulus(2'b00, 6'b000101, 4'd0, 4'b0000, 4'b0110);
      checkOutput("sub_eq_blocked", RegWrite, 0);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0000, 4'b0000);
      checkOutput("flag_write_gated", RegWrite, 0);

      // SUB S=1 under AL loads Z=1, C=1.
      applyStimulus(2'b00, 6'b000101, 4'd0, 4'b1110, 4'b0110);
      checkOutput("subs_aluctl", ALUControl, 2'b01);
      checkOutput("subs_regwrite", RegWrite, 1);
      applyStimulus(2'b00, 6'b000100, 4'd0, 4'b0000, 4'b0000);
      checkOutput("eq_after_subs", RegWrite, 1);
      checkOutput("sub_aluctl", ALUControl, 2'b01);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0010, 4'b0000);
      checkOutput("cs_after_subs", RegWrite, 1);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b1000, 4'b0000);
      checkOutput("hi_after_subs", RegWrite, 0);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b1001, 4'b0000);
      checkOutput("ls_after_subs", RegWrite, 1);

      // Stored N=1, V=0.
      applyStimulus(2'b00, 6'b000101, 4'd0, 4'b1110, 4'b1000);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b1010, 4'b0000);
      checkOutput("ge_n1v0", RegWrite, 0);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b1011, 4'b0000);
      checkOutput("lt_n1v0", RegWrite, 1);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b1100, 4'b0000);
      checkOutput("gt_n1v0", RegWrite, 0);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b1101, 4'b0000);
      checkOutput("le_n1v0", RegWrite, 1);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0100, 4'b0000);
      checkOutput("mi_n1v0", RegWrite, 1);

      // ANDS updates only N,Z: stored becomes N=0 Z=1, C/V stay 0.
      applyStimulus(2'b00, 6'b000001, 4'd0, 4'b1110, 4'b0111);
      checkOutput("ands_aluctl", ALUControl, 2'b10);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0000, 4'b0000);
      checkOutput("eq_after_ands", RegWrite, 1);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0010, 4'b0000);
      checkOutput("cs_after_ands", RegWrite, 0);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0110, 4'b0000);
      checkOutput("vs_after_ands", RegWrite, 0);
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0101, 4'b0000);
      checkOutput("pl_after_ands", RegWrite, 1);

      applyStimulus(2'b00, 6'b011000, 4'd0, 4'b1110, 4'b0000);
      checkOutput("orr_aluctl", ALUControl, 2'b11);
      applyStimulus(2'b00, 6'b011110, 4'd0, 4'b1110, 4'b0000);
      checkOutput("other_cmd_aluctl", ALUControl, 2'b00);
      checkOutput("other_cmd_regwrite", RegWrite, 1);

      // Asynchronous reset clears stored Z=1 without a clock edge.
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0000, 4'b0000);
      checkOutput("eq_before_reset", RegWrite, 1);
      reset = 1'b1;
      #1;
      checkOutput("eq_after_reset", RegWrite, 0);
      checkOutput("reset_comb_aluctl", ALUControl, 2'b00);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(2'b00, 6'b001000, 4'd15, 4'b1110, 4'b0000);
      checkOutput("rd15_pcsrc", PCSrc, 1);
      checkOutput("rd15_regwrite", RegWrite, 1);
      applyStimulus(2'b00, 6'b001000, 4'd15, 4'b1111, 4'b0000);
      checkOutput("nv_pcsrc", PCSrc, 0);
      checkOutput("nv_regwrite", RegWrite, 0);

      applyStimulus(2'b11, 6'b000001, 4'd15, 4'b1110, 4'b0000);
      checkOutput("undef_regwrite", RegWrite, 0);
      checkOutput("undef_memwrite", MemWrite, 0);
      checkOutput("undef_pcsrc", PCSrc, 0);
      checkOutput("undef_memtoreg", MemtoReg, 0);
      checkOutput("undef_immsrc", ImmSrc, 2'b00);

      // Cmd 1010 with S=1 loads C=1 in both builds.
      applyStimulus(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b0010);
`ifdef CONTROL_UNIT_CMP_EN
      checkOutput("cmp_aluctl", ALUControl, 2'b01);
      checkOutput("cmp_regwrite", RegWrite, 0);
`else
      checkOutput("cmd1010_aluctl", ALUControl, 2'b00);
      checkOutput("cmd1010_regwrite", RegWrite, 1);
`endif
      applyStimulus(2'b00, 6'b001000, 4'd0, 4'b0010, 4'b0000);
      checkOutput("cs_after_cmd1010", RegWrite, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arm_control_unit.md
Name: arm_control_unit

Overview:
- Control unit for the single-cycle ARM processor (Harris & Harris subset). Sits between instruction fields and the datapath.
- Decodes Op/Funct/Rd into datapath controls.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field.
- Gates PCSrc/RegWrite/MemWrite with the condition result.

Parameters:
- none (fixed ARM encoding widths)

Ports:
- clk  in  1  system clock, flag register updates on rising edge
- reset  in  1  asynchronous, active-high; clears flag register
- Rd  in  4  destination register field Instr[15:12]
- Op  in  2  Instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (memory: [0]=L)
- Cond  in  4  Instr[31:28] condition code
- N, Z, C, V  in  1 each  ALU flags of the current instruction
- PCSrc  out  1  select ALU result as next PC
- MemtoReg  out  1  writeback selects memory read data
- MemWrite  out  1  data memory write enable
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24 branch
- RegWrite  out  1  register file write enable
- RegSrc  out  2  [0] RA1 = R15, [1] RA2 = Rd

Behaviour:
- All outputs are combinational from inputs and stored flags; only the 4-bit flag register {N,Z,C,V} is sequential. Reset value 0000.
- Main decode (pre-condition values RegW, MemW, Branch, ALUOp):
  - Op=00, DP: RegSrc=00, ImmSrc=00, MemtoReg=0, RegW=1, MemW=0, Branch=0, ALUOp=1.
  - Op=01, Funct[0]=0 (STR): RegSrc=10, ImmSrc=01, MemtoReg=0, RegW=0, MemW=1, ALUOp=0.
  - Op=01, Funct[0]=1 (LDR): RegSrc=00, ImmSrc=01, MemtoReg=1, RegW=1, MemW=0, ALUOp=0.
  - Op=10 (B): RegSrc=01, ImmSrc=10, MemtoReg=0, RegW=0, MemW=0, Branch=1, ALUOp=0.
  - Op=11: all controls 0.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, by cmd: 0100→00, 0010→01, 0000→10, 1100→11; any other cmd→00.
  - FlagW[1] (N,Z) = S.
  - FlagW[0] (C,V) = S & (ALUControl is 00 or 01).
- PCS = Branch | (RegW & Rd==4'hF).
- CondEx from stored flags:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 =1; 1111 =0.
- PCSrc = PCS&CondEx; RegWrite = RegW&CondEx; MemWrite = MemW&CondEx. MemtoReg/ALUControl/ImmSrc/RegSrc are not gated.
- Flag register update, rising clk:
  - If FlagW[1]&CondEx: load stored N,Z from inputs N,Z.
  - If FlagW[0]&CondEx: load stored C,V from inputs C,V.
  - Otherwise hold.
- Flags written by an instruction affect the condition of the next instruction only; there is no same-cycle bypass.
- Reset asserted mid-operation clears flags immediately. Combinational outputs continue to follow inputs.

Optional Feature:
- Macro CONTROL_UNIT_CMP_EN.
- Defined: DP cmd 1010 (CMP) decodes as ALUControl=01 with RegW forced 0. FlagW[1]=FlagW[0]=S.
- Undefined: cmd 1010 takes the default path (ALUControl=00, RegW=1, FlagW[0]=S).

Test Plan:
- After reset, Cond=1110, Op=00, Funct=001000 (ADD, S=0), Rd=0 → ALUControl=00, RegWrite=1, PCSrc=0, MemWrite=0.
- Op=01, Funct=000001, Rd=2, Cond=1110 → MemtoReg=1, RegWrite=1, MemWrite=0, ImmSrc=01. Then Funct=000000 → MemWrite=1, RegWrite=0, RegSrc=10.
- Op=10, Cond=1110 → PCSrc=1, ImmSrc=10, RegSrc=01, RegWrite=0.
- Stored Z=0, Cond=0000, Op=00, Funct=001000, Z input=1 → RegWrite=0 (input flags ignored, no write since S=0).
- Funct=000101 (SUB, S=1), Cond=1110, Z=1, then clk edge; then Cond=0000 → RegWrite=1, ALUControl=01. Assert reset → flags 0000, RegWrite=0 under EQ.
- Op=00, Rd=15, Cond=1110 → PCSrc=1. Same with Cond=1111 → PCSrc=0, RegWrite=0.
